// File: rtl/sd_pkg.sv
// sd_pkg: shared definitions for the SD read path.
//   sd_state_t      - read engine FSM states
//   SD_SECTOR_SHIFT - log2 of the sector size in bytes (512-byte sectors)
//   SD_BLOCK_WORDS  - default 32-bit words per sector
package sd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETADDR,
      READ,
      DRAIN,
      DONE
   } sd_state_t;

   localparam int unsigned SD_SECTOR_SHIFT = 9;
   localparam int unsigned SD_BLOCK_WORDS  = 128;

endpackage

// File: rtl/sd_sync_fifo.sv
// sd_sync_fifo: single-clock FIFO with combinational read of the head entry.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (flushes the FIFO)
//   push        - write push_data (ignored when full unless a pop happens too)
//   push_data   - WIDTH-bit entry
//   pop         - remove the head entry (ignored when empty)
//   pop_data    - head entry, valid while !empty
//   count       - number of stored entries (0..DEPTH)
//   full, empty - occupancy flags
module sd_sync_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   // A pop in the same cycle frees the slot, so push-on-full is legal then.
   assign do_push  = push && (!full || pop);
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sd_read_engine.sv
// sd_read_engine: turns sector-read requests into helper reads and a
// valid/ready word stream.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   req_valid/req_ready  - request handshake (ready only in IDLE)
//   req_sector, req_nblk - start sector and sector count (0 = empty request)
//   sd_setaddr, sd_addr  - one-cycle address load pulse and byte address
//   sd_ren, sd_data      - word read strobe and returned data (one cycle later)
//   out_valid/out_ready  - output stream handshake
//   out_data, out_last   - stream word and end-of-request marker
//   busy, done           - engine active; one-cycle completion pulse
module sd_read_engine
   import sd_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned BLOCK_WORDS = SD_BLOCK_WORDS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_sector,
   input  logic [7:0]  req_nblk,
   output logic        sd_setaddr,
   output logic [31:0] sd_addr,
   output logic        sd_ren,
   input  logic [31:0] sd_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        busy,
   output logic        done
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   sd_state_t   state;
   sd_state_t   state_next;

   logic [31:0] addr_reg;
   logic [15:0] total;
   logic [15:0] issued;
   logic [15:0] delivered;
   logic        inflight;
   logic        accept;
   logic        credit_ok;
   logic [31:0] occupancy;

   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_push;
   logic          fifo_pop;
   logic [32:0]   fifo_push_data;
   logic [32:0]   fifo_pop_data;

   assign accept = req_valid && req_ready;

   // The in-flight read already owns a FIFO slot, so it counts against credit.
   assign occupancy = 32'(fifo_count) + 32'(inflight);
   assign credit_ok = (occupancy < FIFO_DEPTH);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = (req_nblk == '0) ? DONE : SETADDR;
            end
         end
         SETADDR: state_next = READ;
         READ: begin
            if (sd_ren && (issued == total - 16'd1)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty && !inflight) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      req_ready  = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      sd_setaddr = 1'b0;
      sd_ren     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
         SETADDR: sd_setaddr = 1'b1;
         READ:    sd_ren     = credit_ok && (issued < total);
         DONE:    done       = 1'b1;
         default: ;
      endcase
   end

   // Request capture, counters and the one-deep read pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg  <= '0;
         total     <= '0;
         issued    <= '0;
         delivered <= '0;
         inflight  <= 1'b0;
      end else begin
         if (accept) begin
            // Upper sector bits fall off the top: the byte address wraps.
            addr_reg  <= req_sector << SD_SECTOR_SHIFT;
            total     <= 16'(req_nblk) * 16'(BLOCK_WORDS);
            issued    <= '0;
            delivered <= '0;
         end
         if (sd_ren) begin
            issued <= issued + 16'd1;
         end
         if (fifo_push) begin
            delivered <= delivered + 16'd1;
         end
         inflight <= sd_ren;
      end
   end

   assign sd_addr = addr_reg;

   // Helper data is valid the cycle after the strobe and is written straight
   // into the FIFO at the end of that cycle.
   assign fifo_push      = inflight;
   assign fifo_push_data = {(delivered == total - 16'd1), sd_data};
   assign fifo_pop       = out_valid && out_ready;

   sd_sync_fifo #(
      .WIDTH (33),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_pop_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   // Mask the stale head entry so the idle stream reads as zero.
   assign out_data  = out_valid ? fifo_pop_data[31:0] : '0;
   assign out_last  = out_valid ? fifo_pop_data[32]   : 1'b0;

endmodule

// File: tb/tb_sd_read_engine.sv
// tb_sd_read_engine: directed bench for sd_read_engine with a helper model
// and an expected-word scoreboard.
module tb_sd_read_engine;

   localparam int unsigned BW = 128;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_sector;
   logic [7:0]  req_nblk;
   logic        sd_setaddr;
   logic [31:0] sd_addr;
   logic        sd_ren;
   logic [31:0] sd_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   sd_read_engine #(
      .FIFO_DEPTH  (4),
      .BLOCK_WORDS (128)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_sector (req_sector),
      .req_nblk   (req_nblk),
      .sd_setaddr (sd_setaddr),
      .sd_addr    (sd_addr),
      .sd_ren     (sd_ren),
      .sd_data    (sd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } word_t;

   word_t       exp_q[$];
   logic [31:0] setaddr_log[$];
   int unsigned acc_log[$];
   int unsigned done_log[$];
   int          n_setaddr, n_ren, n_done, n_pop, n_acc;
   int unsigned setaddr_cyc, first_ren_cyc, first_valid_cyc, last_pop_cyc;
   logic        busy_at_done;
   int          full_seen, ren_while_full;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic        prev_last;

   function automatic logic [31:0] helper_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Helper model: latches the address on setaddr, returns one word per strobe.
   logic [31:0] haddr = '0;
   always @(posedge clk) begin
      if (sd_setaddr) begin
         haddr <= sd_addr;
      end else if (sd_ren) begin
         sd_data <= helper_word(haddr);
         haddr   <= haddr + 32'd4;
      end
   end

   // Per-cycle monitor and scoreboard consumer.
   always @(negedge clk) begin
      word_t w;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         chk("setaddr_ren_exclusive", 64'(sd_setaddr & sd_ren), 64'd0);
         chk("fifo_count_bound", 64'(dut.fifo_count <= 4), 64'd1);
         if (dut.fifo_count == 4) begin
            full_seen++;
            if (sd_ren) ren_while_full++;
         end
         if (sd_setaddr) begin
            n_setaddr++;
            setaddr_log.push_back(sd_addr);
            setaddr_cyc = cyc;
         end
         if (sd_ren) begin
            n_ren++;
            if (first_ren_cyc == 0) first_ren_cyc = cyc;
         end
         if (out_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
         if (done) begin
            n_done++;
            done_log.push_back(cyc);
            busy_at_done = busy;
         end
         if (req_valid && req_ready) begin
            n_acc++;
            acc_log.push_back(cyc);
         end
         if (prev_stall) begin
            chk("stall_data_stable", 64'(out_data), 64'(prev_data));
            chk("stall_last_stable", 64'(out_last), 64'(prev_last));
         end
         if (out_valid && out_ready) begin
            n_pop++;
            last_pop_cyc = cyc;
            chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               w = exp_q.pop_front();
               chk("word_data", 64'(out_data), 64'(w.data));
               chk("word_last", 64'(out_last), 64'(w.last));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic clear_stats();
      n_setaddr = 0; n_ren = 0; n_done = 0; n_pop = 0; n_acc = 0;
      setaddr_cyc = 0; first_ren_cyc = 0; first_valid_cyc = 0; last_pop_cyc = 0;
      full_seen = 0; ren_while_full = 0; busy_at_done = 1'b0;
      setaddr_log.delete(); acc_log.delete(); done_log.delete();
   endtask

   task automatic push_expect(input logic [31:0] sector, input logic [7:0] nblk);
      logic [31:0] base;
      int unsigned total;
      base  = sector << 9;
      total = int'(nblk) * BW;
      for (int unsigned i = 0; i < total; i++) begin
         exp_q.push_back('{data: helper_word(base + 32'(4 * i)), last: (i == total - 1)});
      end
   endtask

   // Returns the cycle id of the cycle following acceptance.
   task automatic issue_req(input logic [31:0] sector, input logic [7:0] nblk,
                            output int unsigned acc_next);
      push_expect(sector, nblk);
      @(posedge clk); #1;
      req_valid  = 1'b1;
      req_sector = sector;
      req_nblk   = nblk;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      acc_next   = cyc;
   endtask

   task automatic wait_done(input int start, input int bound, input string tag);
      for (int i = 0; i < bound && n_done == start; i++) @(posedge clk);
      chk(tag, 64'(n_done > start), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"},  64'(req_ready),  64'd1);
      chk({tag, "_busy"},       64'(busy),       64'd0);
      chk({tag, "_done"},       64'(done),       64'd0);
      chk({tag, "_sd_setaddr"}, 64'(sd_setaddr), 64'd0);
      chk({tag, "_sd_ren"},     64'(sd_ren),     64'd0);
      chk({tag, "_sd_addr"},    64'(sd_addr),    64'd0);
      chk({tag, "_out_valid"},  64'(out_valid),  64'd0);
      chk({tag, "_out_last"},   64'(out_last),   64'd0);
      chk({tag, "_out_data"},   64'(out_data),   64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned acc;
      int          nd;

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_sector = '0;
      req_nblk   = '0;
      out_ready  = 1'b1;
      clear_stats();

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Single sector, consumer always ready
      clear_stats();
      issue_req(32'd5, 8'd1, acc);
      wait_done(0, 1000, "t1_done_seen");
      #1;
      chk("t1_ready_after_done", 64'(req_ready), 64'd1);
      chk("t1_setaddr_count", 64'(n_setaddr), 64'd1);
      chk("t1_setaddr_addr", 64'(setaddr_log[0]), 64'h0000_0A00);
      chk("t1_setaddr_cycle", 64'(setaddr_cyc), 64'(acc));
      chk("t1_first_ren_latency", 64'(first_ren_cyc >= acc + 1), 64'd1);
      chk("t1_first_valid_latency", 64'(first_valid_cyc >= acc + 3), 64'd1);
      chk("t1_ren_count", 64'(n_ren), 64'd128);
      chk("t1_pop_count", 64'(n_pop), 64'd128);
      chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("t1_throughput", 64'(last_pop_cyc - first_valid_cyc), 64'd127);
      chk("t1_done_after_last", 64'(done_log[0] > last_pop_cyc), 64'd1);
      repeat (5) @(posedge clk);
      chk("t1_done_once", 64'(n_done), 64'd1);

      // Empty request
      clear_stats();
      issue_req(32'h99, 8'd0, acc);
      wait_done(0, 10, "t2_done_seen");
      #1;
      chk("t2_done_window", 64'(done_log[0] >= acc && done_log[0] <= acc + 1), 64'd1);
      chk("t2_busy_at_done", 64'(busy_at_done), 64'd1);
      chk("t2_ready_after_done", 64'(req_ready), 64'd1);
      chk("t2_no_setaddr", 64'(n_setaddr), 64'd0);
      chk("t2_no_ren", 64'(n_ren), 64'd0);

      // Two sectors with random and sustained backpressure
      clear_stats();
      issue_req(32'h33, 8'd2, acc);
      for (int i = 0; i < 3000 && n_done == 0; i++) begin
         @(posedge clk); #1;
         out_ready = (i >= 10 && i < 30) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      chk("t3_done_seen", 64'(n_done), 64'd1);
      out_ready = 1'b1;
      chk("t3_pop_count", 64'(n_pop), 64'd256);
      chk("t3_ren_count", 64'(n_ren), 64'd256);
      chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("t3_fifo_filled", 64'(full_seen > 0), 64'd1);
      chk("t3_no_ren_without_credit", 64'(ren_while_full), 64'd0);

      // Sector number beyond 32-bit byte addressing wraps
      clear_stats();
      issue_req(32'h0080_0001, 8'd1, acc);
      wait_done(0, 1000, "t4_done_seen");
      chk("t4_wrap_addr", 64'(setaddr_log[0]), 64'h0000_0200);
      chk("t4_pop_count", 64'(n_pop), 64'd128);
      chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of a read with words buffered
      clear_stats();
      out_ready = 1'b0;
      issue_req(32'h44, 8'd1, acc);
      for (int i = 0; i < 200 && dut.fifo_count != 3; i++) begin
         @(posedge clk); #1;
      end
      chk("t5_three_buffered", 64'(dut.fifo_count), 64'd3);
      chk("t5_busy_before_reset", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t5_abort");
      exp_q.delete();
      nd = n_done;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      chk("t5_no_done", 64'(n_done), 64'(nd));
      out_ready = 1'b1;
      clear_stats();
      issue_req(32'h7, 8'd1, acc);
      wait_done(0, 1000, "t5_next_done_seen");
      chk("t5_next_addr", 64'(setaddr_log[0]), 64'h0000_0E00);
      chk("t5_next_pop_count", 64'(n_pop), 64'd128);
      chk("t5_next_queue_empty", 64'(exp_q.size()), 64'd0);

      // Back-to-back requests with req_valid held high
      clear_stats();
      push_expect(32'h10, 8'd1);
      push_expect(32'h20, 8'd1);
      @(posedge clk); #1;
      req_valid  = 1'b1;
      req_sector = 32'h10;
      req_nblk   = 8'd1;
      @(posedge clk); #1;
      req_sector = 32'h20;
      for (int i = 0; i < 1000 && n_acc < 2; i++) @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_done(1, 1000, "t6_second_done_seen");
      chk("t6_accept_count", 64'(n_acc), 64'd2);
      chk("t6_second_accept_after_done", 64'(acc_log[1]), 64'(done_log[0] + 1));
      chk("t6_setaddr_count", 64'(n_setaddr), 64'd2);
      chk("t6_second_addr", 64'(setaddr_log[1]), 64'h0000_4000);
      chk("t6_pop_count", 64'(n_pop), 64'd256);
      chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("t6_done_count", 64'(n_done), 64'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
